// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared TDM state encodings, counter-width helper and defaults
package tdm_demux_pkg;
  typedef enum logic {TDM_HUNT = 1'b0, TDM_LOCKED = 1'b1} tdm_state_t;
  localparam int TDM_DEF_SLOTS = 2;
  localparam int TDM_DEF_WIDTH = 1;
  function automatic int tdm_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial slot stream in, parallel frame and framing status out
interface tdm_demux_if import tdm_demux_pkg::*; #(
  parameter int WIDTH = TDM_DEF_WIDTH,
  parameter int SLOTS = TDM_DEF_SLOTS
);
  logic                   sync;
  logic [WIDTH-1:0]       din;
  logic [SLOTS*WIDTH-1:0] dout;
  logic                   frame_valid;
  logic                   locked;
  logic                   sync_err;
  modport master (output sync, din, input dout, frame_valid, locked, sync_err);
  modport slave (input sync, din, output dout, frame_valid, locked, sync_err);
endinterface

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: mod-SLOTS counter with sync clear, load-to-1 and terminal count
module tdm_slot_counter import tdm_demux_pkg::*; #(
  parameter int SLOTS = TDM_DEF_SLOTS,
  parameter int CW    = tdm_clog2(SLOTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load1,
  input  logic          en,
  output logic [CW-1:0] slot,
  output logic          tc
);
  assign tc = slot == CW'(SLOTS - 1);
  always_ff @(posedge clk)
    if (rst || clr) slot <= '0;
    else if (load1) slot <= CW'(1);
    else if (en) slot <= tc ? '0 : slot + CW'(1);
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: locks to a sync-marked TDM stream and publishes whole frames in parallel
module tdm_demux import tdm_demux_pkg::*; #(
  parameter int WIDTH = TDM_DEF_WIDTH,
  parameter int SLOTS = TDM_DEF_SLOTS
) (
  input logic       clk,
  input logic       rst,
  tdm_demux_if.slave bus
);
  localparam int CW = tdm_clog2(SLOTS);
  tdm_state_t                 state;
  logic [(SLOTS-1)*WIDTH-1:0] shadow;
  logic [SLOTS*WIDTH-1:0]     dout;
  logic                       frame_valid, sync_err, tc, at0, locked;
  logic [CW-1:0]              slot;
  assign locked = state == TDM_LOCKED;
  assign at0 = slot == '0;
  // any sync restarts the frame; a sync-less slot 0 (or HUNT) parks the counter at 0
  tdm_slot_counter #(.SLOTS(SLOTS), .CW(CW)) u_cnt (
    .clk(clk), .rst(rst),
    .clr(!bus.sync && (!locked || at0)),
    .load1(bus.sync),
    .en(!bus.sync && locked && !at0),
    .slot(slot), .tc(tc)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state       <= TDM_HUNT;
      shadow      <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (bus.sync) begin
        shadow[WIDTH-1:0] <= bus.din;
        state             <= TDM_LOCKED;
        sync_err          <= locked && !at0;
      end else if (locked) begin
        if (at0) begin
          sync_err <= 1'b1;
          state    <= TDM_HUNT;
        end else if (tc) begin
          dout        <= {bus.din, shadow};
          frame_valid <= 1'b1;
        end else shadow[int'(slot)*WIDTH +: WIDTH] <= bus.din;
      end
    end
  assign bus.dout        = dout;
  assign bus.frame_valid = frame_valid;
  assign bus.locked      = locked;
  assign bus.sync_err    = sync_err;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for 2x1-bit and 4x8-bit demux instances
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst2 = 1'b1;
  logic rst4 = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [1:0]  q2[$];
  logic [31:0] q4[$];
  logic [1:0]  e2 = '0;
  logic [31:0] e4 = '0;
  logic [1:0]  sw[4] = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic [7:0]  b[4];
  always #5 clk = ~clk;
  tdm_demux_if #(.WIDTH(1), .SLOTS(2)) i2 ();
  tdm_demux_if #(.WIDTH(8), .SLOTS(4)) i4 ();
  tdm_demux #(.WIDTH(1), .SLOTS(2)) u2 (.clk(clk), .rst(rst2), .bus(i2.slave));
  tdm_demux #(.WIDTH(8), .SLOTS(4)) u4 (.clk(clk), .rst(rst4), .bus(i4.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step2(input logic r, input logic s, input logic d, input logic el, input logic ee);
    rst2 = r;
    i2.sync = s;
    i2.din = d;
    @(posedge clk);
    #1;
    check("fv2", 32'(i2.frame_valid), 32'(q2.size() != 0));
    if (q2.size() != 0) e2 = q2.pop_front();
    if (r) e2 = '0;
    check("dout2", 32'(i2.dout), 32'(e2));
    check("locked2", 32'(i2.locked), 32'(el));
    check("err2", 32'(i2.sync_err), 32'(ee));
  endtask
  task automatic step4(input logic r, input logic s, input logic [7:0] d, input logic el, input logic ee);
    rst4 = r;
    i4.sync = s;
    i4.din = d;
    @(posedge clk);
    #1;
    check("fv4", 32'(i4.frame_valid), 32'(q4.size() != 0));
    if (q4.size() != 0) e4 = q4.pop_front();
    if (r) e4 = '0;
    check("dout4", i4.dout, e4);
    check("locked4", 32'(i4.locked), 32'(el));
    check("err4", 32'(i4.sync_err), 32'(ee));
  endtask
  initial begin
    i2.sync = 1'b0;
    i2.din = 1'b0;
    i4.sync = 1'b0;
    i4.din = '0;
    repeat (2) step2(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step4(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step2(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step4(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step2(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      q2.push_back(2'b01);
      step2(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step2(1'b0, 1'b1, sw[i][1], 1'b1, 1'b0);
      q2.push_back({sw[i][0], sw[i][1]});
      step2(1'b0, 1'b0, sw[i][0], 1'b1, 1'b0);
    end
    step2(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step2(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    q2.push_back(2'b10);
    step2(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step2(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step2(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step2(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step4(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    step4(1'b0, 1'b0, 8'h22, 1'b1, 1'b0);
    step4(1'b0, 1'b1, 8'hA0, 1'b1, 1'b1);
    step4(1'b0, 1'b0, 8'hA1, 1'b1, 1'b0);
    step4(1'b0, 1'b0, 8'hA2, 1'b1, 1'b0);
    q4.push_back(32'hA3A2A1A0);
    step4(1'b0, 1'b0, 8'hA3, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
      step4(1'b0, 1'b1, b[0], 1'b1, 1'b0);
      step4(1'b0, 1'b0, b[1], 1'b1, 1'b0);
      step4(1'b0, 1'b0, b[2], 1'b1, 1'b0);
      q4.push_back({b[3], b[2], b[1], b[0]});
      step4(1'b0, 1'b0, b[3], 1'b1, 1'b0);
    end
    step4(1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);
    step4(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step4(1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    step4(1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
    step4(1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
